// File: rtl/sram_sp_arbiter_pkg.sv
// Shared types and constants for the single-port SRAM arbiter slice.
package sram_arb_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int AW_DEF = 9;
    localparam int DW_DEF = 16;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

endpackage

// File: rtl/sram_sp_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer advances on accept.
module rr_arb2
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    // ptr_q = 1 means B was granted most recently, so A wins the next tie
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = gnt[REQ_B];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram_sp_arbiter.sv
// Two-requester front end for a 512x16 single-port SRAM with optional zero-fill
// after reset and round-robin grant of one access per cycle.
module sram_sp_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          init_busy,

    input  logic          a_req_valid,
    output logic          a_req_ready,
    input  logic          a_req_we,
    input  logic [AW-1:0] a_req_addr,
    input  logic [DW-1:0] a_req_wdata,
    output logic          a_rsp_valid,
    output logic [DW-1:0] a_rsp_rdata,

    input  logic          b_req_valid,
    output logic          b_req_ready,
    input  logic          b_req_we,
    input  logic [AW-1:0] b_req_addr,
    input  logic [DW-1:0] b_req_wdata,
    output logic          b_rsp_valid,
    output logic [DW-1:0] b_rsp_rdata,

    output logic [AW-1:0] sram_adr,
    output logic [DW-1:0] sram_d,
    output logic          sram_we,
    output logic          sram_me,
    input  logic [DW-1:0] sram_q
);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          a_rsp_q, a_rsp_d;
    logic          b_rsp_q, b_rsp_d;

    logic [1:0]    req;
    logic [1:0]    gnt;
    logic          in_run;

    assign in_run = (state_q == ST_RUN);

    // Requests are masked in reset and during fill, so a grant always means a handshake
    assign req = {b_req_valid, a_req_valid} & {2{in_run & rst_n}};

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .accept (|gnt),
        .gnt    (gnt)
    );

    assign a_req_ready = gnt[REQ_A];
    assign b_req_ready = gnt[REQ_B];
    assign init_busy   = (state_q == ST_INIT);

    always_comb begin
        sram_me  = 1'b0;
        sram_we  = 1'b0;
        sram_adr = '0;
        sram_d   = '0;
        if (rst_n) begin
            if (state_q == ST_INIT) begin
                sram_me  = 1'b1;
                sram_we  = 1'b1;
                sram_adr = cnt_q;
            end else if (gnt[REQ_A]) begin
                sram_me  = 1'b1;
                sram_we  = a_req_we;
                sram_adr = a_req_addr;
                sram_d   = a_req_wdata;
            end else if (gnt[REQ_B]) begin
                sram_me  = 1'b1;
                sram_we  = b_req_we;
                sram_adr = b_req_addr;
                sram_d   = b_req_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {AW{1'b1}}) begin
                state_d = ST_RUN;
            end
        end
        a_rsp_d = gnt[REQ_A] & ~a_req_we;
        b_rsp_d = gnt[REQ_B] & ~b_req_we;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT_CLEAR ? ST_INIT : ST_RUN;
            cnt_q   <= '0;
            a_rsp_q <= 1'b0;
            b_rsp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_rsp_q <= a_rsp_d;
            b_rsp_q <= b_rsp_d;
        end
    end

    // Macro Q holds between accesses, so it is still valid in the response cycle
    assign a_rsp_valid = a_rsp_q;
    assign b_rsp_valid = b_rsp_q;
    assign a_rsp_rdata = a_rsp_q ? sram_q : '0;
    assign b_rsp_rdata = b_rsp_q ? sram_q : '0;

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Directed bench for sram_sp_arbiter with a behavioural single-port SRAM model.
module tb_sram_sp_arbiter;

    logic        clk;
    logic        rst_n;
    logic        init_busy;
    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
    logic [8:0]  a_req_addr;
    logic [15:0] a_req_wdata, a_rsp_rdata;
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
    logic [8:0]  b_req_addr;
    logic [15:0] b_req_wdata, b_rsp_rdata;
    logic [8:0]  sram_adr;
    logic [15:0] sram_d, sram_q;
    logic        sram_we, sram_me;

    logic [15:0] mem [0:511];

    int errors = 0;
    int checks = 0;

    sram_sp_arbiter #(.AW(9), .DW(16), .INIT_CLEAR(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .init_busy   (init_busy),
        .a_req_valid (a_req_valid),
        .a_req_ready (a_req_ready),
        .a_req_we    (a_req_we),
        .a_req_addr  (a_req_addr),
        .a_req_wdata (a_req_wdata),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_rdata (a_rsp_rdata),
        .b_req_valid (b_req_valid),
        .b_req_ready (b_req_ready),
        .b_req_we    (b_req_we),
        .b_req_addr  (b_req_addr),
        .b_req_wdata (b_req_wdata),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_rdata (b_rsp_rdata),
        .sram_adr    (sram_adr),
        .sram_d      (sram_d),
        .sram_we     (sram_we),
        .sram_me     (sram_me),
        .sram_q      (sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: registered read, Q holds when not reading
    always @(posedge clk) begin
        if (sram_me) begin
            if (sram_we) mem[sram_adr] <= sram_d;
            else         sram_q <= mem[sram_adr];
        end
    end

    // Requester obligation: a stalled command stays valid and unchanged
    logic        a_hold, b_hold;
    logic [25:0] a_cmd_s, b_cmd_s;
    always @(posedge clk) begin
        if (rst_n && a_hold && !(a_req_valid && {a_req_we, a_req_addr, a_req_wdata} == a_cmd_s))
            $error("FAIL proto_a: command changed while stalled");
        if (rst_n && b_hold && !(b_req_valid && {b_req_we, b_req_addr, b_req_wdata} == b_cmd_s))
            $error("FAIL proto_b: command changed while stalled");
        a_hold  <= rst_n && a_req_valid && !a_req_ready;
        b_hold  <= rst_n && b_req_valid && !b_req_ready;
        a_cmd_s <= {a_req_we, a_req_addr, a_req_wdata};
        b_cmd_s <= {b_req_we, b_req_addr, b_req_wdata};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic ea, eb;
        rst_n = 1'b0;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state; A already presents a read of the top word
        a_req_valid = 1'b1; a_req_addr = 9'h1FF;
        #1;
        check("rst_busy",  32'(init_busy),   32'd1);
        check("rst_me",    32'(sram_me),     32'd0);
        check("rst_we",    32'(sram_we),     32'd0);
        check("rst_aready",32'(a_req_ready), 32'd0);
        check("rst_arsp",  32'(a_rsp_valid), 32'd0);
        check("rst_brsp",  32'(b_rsp_valid), 32'd0);

        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 512; i++) begin
            check("fill_busy",  32'(init_busy),   32'd1);
            check("fill_me",    32'(sram_me),     32'd1);
            check("fill_we",    32'(sram_we),     32'd1);
            check("fill_adr",   32'(sram_adr),    32'(i));
            check("fill_d",     32'(sram_d),      32'd0);
            check("fill_aready",32'(a_req_ready), 32'd0);
            next_cycle();
        end

        // First RUN cycle: held A read is accepted immediately
        check("run_busy",   32'(init_busy),   32'd0);
        check("run_aready", 32'(a_req_ready), 32'd1);
        check("run_me",     32'(sram_me),     32'd1);
        check("run_we",     32'(sram_we),     32'd0);
        check("run_adr",    32'(sram_adr),    32'h1FF);
        next_cycle();
        a_req_valid = 1'b0;
        check("rd1ff_vld",  32'(a_rsp_valid), 32'd1);
        check("rd1ff_data", 32'(a_rsp_rdata), 32'h0000);
        check("rd1ff_brsp", 32'(b_rsp_valid), 32'd0);

        // Write then read back from A
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 9'h055; a_req_wdata = 16'hBEEF;
        #1;
        check("wr_aready", 32'(a_req_ready), 32'd1);
        check("wr_we",     32'(sram_we),     32'd1);
        check("wr_d",      32'(sram_d),      32'hBEEF);
        next_cycle();
        a_req_we = 1'b0;
        #1;
        check("rd_aready",  32'(a_req_ready), 32'd1);
        check("wr_norsp",   32'(a_rsp_valid), 32'd0);
        next_cycle();
        a_req_valid = 1'b0;
        #1;
        check("rd55_vld",   32'(a_rsp_valid), 32'd1);
        check("rd55_data",  32'(a_rsp_rdata), 32'hBEEF);
        check("rd55_brsp",  32'(b_rsp_valid), 32'd0);
        next_cycle();
        check("rsp_pulse",  32'(a_rsp_valid), 32'd0);
        check("rsp_zero",   32'(a_rsp_rdata), 32'd0);
        check("idle_me",    32'(sram_me),     32'd0);
        check("idle_adr",   32'(sram_adr),    32'd0);

        // Preload: A writes 0x020, then B writes 0x030 (B becomes most recent)
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 9'h020; a_req_wdata = 16'h2222;
        next_cycle();
        a_req_valid = 1'b0;
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 9'h030; b_req_wdata = 16'h3333;
        #1;
        check("pre_bready", 32'(b_req_ready), 32'd1);
        next_cycle();

        // Both read continuously: grants alternate starting with A
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 9'h020;
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 9'h030;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) a_req_valid = 1'b0;
            #1;
            ea = (k % 2 == 0);
            eb = (k % 2 == 1);
            check("alt_aready", 32'(a_req_ready), 32'(ea));
            check("alt_bready", 32'(b_req_ready), 32'(eb));
            if (k > 0) begin
                check("alt_arsp",  32'(a_rsp_valid), 32'(eb));
                check("alt_brsp",  32'(b_rsp_valid), 32'(ea));
                check("alt_adata", 32'(a_rsp_rdata), eb ? 32'h2222 : 32'h0);
                check("alt_bdata", 32'(b_rsp_rdata), ea ? 32'h3333 : 32'h0);
            end
            next_cycle();
        end
        b_req_valid = 1'b0;
        #1;
        check("alt_last_brsp",  32'(b_rsp_valid), 32'd1);
        check("alt_last_bdata", 32'(b_rsp_rdata), 32'h3333);
        check("alt_last_arsp",  32'(a_rsp_valid), 32'd0);

        // Same-cycle A write / B read of one address
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 9'h010; a_req_wdata = 16'h1234;
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 9'h010;
        #1;
        check("haz_aready", 32'(a_req_ready), 32'd1);
        check("haz_bready", 32'(b_req_ready), 32'd0);
        next_cycle();
        a_req_valid = 1'b0;
        #1;
        check("haz_bready2", 32'(b_req_ready), 32'd1);
        check("haz_adr",     32'(sram_adr),    32'h010);
        next_cycle();
        b_req_valid = 1'b0;
        #1;
        check("haz_brsp",  32'(b_rsp_valid), 32'd1);
        check("haz_bdata", 32'(b_rsp_rdata), 32'h1234);

        // Reset in RUN drops the pending response and restarts fill
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 9'h055;
        #1;
        check("rr_aready", 32'(a_req_ready), 32'd1);
        next_cycle();
        a_req_valid = 1'b0;
        rst_n = 1'b0;
        next_cycle();
        check("rr_arsp_drop", 32'(a_rsp_valid), 32'd0);
        check("rr_busy",      32'(init_busy),   32'd1);
        rst_n = 1'b1;
        #1;
        check("rr_adr0", 32'(sram_adr), 32'd0);
        check("rr_me",   32'(sram_me),  32'd1);
        repeat (100) next_cycle();
        check("mid_adr100", 32'(sram_adr), 32'd100);
        rst_n = 1'b0;
        #1;
        check("mid_rst_me", 32'(sram_me), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        #1;
        check("restart_adr",  32'(sram_adr),  32'd0);
        check("restart_busy", 32'(init_busy), 32'd1);
        check("restart_me",   32'(sram_me),   32'd1);
        n = 0;
        while (init_busy && n < 1000) begin
            n++;
            next_cycle();
        end
        check("fill_len", 32'(n), 32'd512);

        // Fill cleared the earlier write
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 9'h055;
        #1;
        check("post_aready", 32'(a_req_ready), 32'd1);
        next_cycle();
        a_req_valid = 1'b0;
        #1;
        check("post_arsp",  32'(a_rsp_valid), 32'd1);
        check("post_adata", 32'(a_rsp_rdata), 32'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
